// File: rtl/shift_sched.sv
// Round-robin issue scheduler sharing one two-stage shift unit among NREQ issue queues.
// Optional SHIFT_SCHED_PERF_EN adds per-requester grant counters and a blocked-cycle counter.

module shift_sched_lane #(
   parameter int HW = 1
) (
`ifdef SHIFT_SCHED_PERF_EN
   input  logic             clk,
   input  logic             reset,
   input  logic             grant,
   output logic [31:0]      perf_cnt,
`endif
   input  logic             valid,
   input  logic [HW-1:0]    hart,
   input  logic [2**HW-1:0] flush_ext,
   output logic             elig
);

   // A requester whose hart is being flushed this cycle is skipped by the arbiter.
   assign elig = valid & ~flush_ext[hart];

`ifdef SHIFT_SCHED_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         perf_cnt <= '0;
      else if (grant && perf_cnt != '1)
         perf_cnt <= perf_cnt + 32'd1;
   end
`endif

endmodule

module shift_sched #(
   parameter  int NREQ       = 4,
   parameter  int LNREQ      = 2,
   parameter  int CNTRL_SIZE = 7,
   parameter  int RV         = 64,
   parameter  int LNCOMMIT   = 5,
   parameter  int NHART      = 1,
   parameter  int LNHART     = 0,
   localparam int HW         = (NHART == 1) ? 1 : LNHART
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NREQ-1:0]                     req_valid,
   output logic [NREQ-1:0]                     req_ready,
   input  logic [NREQ-1:0][CNTRL_SIZE-1:0]     req_control,
   input  logic [NREQ-1:0][LNCOMMIT-1:0]       req_rd,
   input  logic [NREQ-1:0]                     req_makes_rd,
   input  logic [NREQ-1:0]                     req_needs_rs2,
   input  logic [NREQ-1:0][31:0]               req_immed,
   input  logic [NREQ-1:0][HW-1:0]             req_hart,
   input  logic [NREQ-1:0]                     req_rv32,
   input  logic [NREQ-1:0][RV-1:0]             req_r1,
   input  logic [NREQ-1:0][RV-1:0]             req_r2,
   input  logic [NREQ-1:0][RV-1:0]             req_r3,
   input  logic                                issue_block,
   input  logic [NHART-1:0]                    flush,
   output logic                                sh_enable,
   output logic [CNTRL_SIZE-1:0]               sh_control,
   output logic [LNCOMMIT-1:0]                 sh_rd,
   output logic                                sh_makes_rd,
   output logic                                sh_needs_rs2,
   output logic [31:0]                         sh_immed,
   output logic [HW-1:0]                       sh_hart,
   output logic                                sh_rv32,
   output logic [RV-1:0]                       sh_r1,
   output logic [RV-1:0]                       sh_r2,
   output logic [RV-1:0]                       sh_r3,
   input  logic [RV-1:0]                       sh_result,
   output logic                                res_valid,
   output logic [LNREQ-1:0]                    res_tag,
   output logic [LNCOMMIT-1:0]                 res_rd,
   output logic [HW-1:0]                       res_hart
`ifdef SHIFT_SCHED_PERF_EN
   ,
   output logic [NREQ-1:0][31:0]               perf_grants,
   output logic [31:0]                         perf_blocked
`endif
);

   localparam int NH2 = 2**HW;

   typedef struct packed {
      logic [LNREQ-1:0]    tag;
      logic [LNCOMMIT-1:0] rd;
      logic [HW-1:0]       hart;
   } ent_t;

   logic [NH2-1:0]   flush_ext;
   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  grant;
   logic [LNREQ-1:0] rr_ptr;
   logic [LNREQ-1:0] win;
   logic [LNREQ:0]   scan;
   logic             found;
   logic [2:1]       vld_pipe;
   ent_t             s1, s2;
   logic             s1_rv32;
   logic             unused_ok;

   // The result data flows straight from the shift unit to writeback; only its timing matters here.
   assign unused_ok = ^sh_result;

   always_comb begin
      flush_ext = '0;
      flush_ext[NHART-1:0] = flush;
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_lane
      shift_sched_lane #(.HW(HW)) u_lane (
`ifdef SHIFT_SCHED_PERF_EN
         .clk       (clk),
         .reset     (reset),
         .grant     (grant[g]),
         .perf_cnt  (perf_grants[g]),
`endif
         .valid     (req_valid[g]),
         .hart      (req_hart[g]),
         .flush_ext (flush_ext),
         .elig      (elig[g])
      );
   end

   // First eligible requester at or after rr_ptr, scanning with wrap-around.
   always_comb begin
      scan  = '0;
      grant = '0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         scan = {1'b0, rr_ptr} + (LNREQ+1)'(k);
         if (scan >= (LNREQ+1)'(NREQ))
            scan = scan - (LNREQ+1)'(NREQ);
         if (!found && elig[scan[LNREQ-1:0]]) begin
            found = 1'b1;
            win   = scan[LNREQ-1:0];
         end
      end
      if (!reset || issue_block)
         found = 1'b0;
      if (found)
         grant[win] = 1'b1;
   end

   assign req_ready = grant;
   assign sh_enable = found;

   always_comb begin
      sh_control   = '0;
      sh_rd        = '0;
      sh_makes_rd  = 1'b0;
      sh_needs_rs2 = 1'b0;
      sh_immed     = '0;
      sh_hart      = '0;
      // Outside a grant cycle the second stage still sees the in-flight op's mode.
      sh_rv32      = vld_pipe[1] & s1_rv32;
      if (found) begin
         sh_control   = req_control[win];
         sh_rd        = req_rd[win];
         sh_makes_rd  = req_makes_rd[win];
         sh_needs_rs2 = req_needs_rs2[win];
         sh_immed     = req_immed[win];
         sh_hart      = req_hart[win];
         sh_rv32      = req_rv32[win];
      end
   end

   // Operands are taken from the granted queue one cycle after the grant.
   always_comb begin
      sh_r1 = '0;
      sh_r2 = '0;
      sh_r3 = '0;
      if (vld_pipe[1]) begin
         sh_r1 = req_r1[s1.tag];
         sh_r2 = req_r2[s1.tag];
         sh_r3 = req_r3[s1.tag];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr   <= '0;
         vld_pipe <= '0;
         s1       <= '0;
         s2       <= '0;
         s1_rv32  <= 1'b0;
      end else begin
         if (found) begin
            rr_ptr  <= (win == LNREQ'(NREQ-1)) ? '0 : win + 1'b1;
            s1      <= '{tag: win, rd: req_rd[win], hart: req_hart[win]};
            s1_rv32 <= req_rv32[win];
         end
         // A new grant never belongs to a flushed hart, so only the S1->S2 hop needs masking.
         vld_pipe[1] <= found;
         vld_pipe[2] <= vld_pipe[1] & ~flush_ext[s1.hart];
         s2          <= s1;
      end
   end

   assign res_valid = vld_pipe[2];
   assign res_tag   = s2.tag;
   assign res_rd    = s2.rd;
   assign res_hart  = s2.hart;

`ifdef SHIFT_SCHED_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         perf_blocked <= '0;
      else if (|req_valid && !found && perf_blocked != '1)
         perf_blocked <= perf_blocked + 32'd1;
   end
`endif

endmodule
